// File: rtl/raster_sequencer_pkg.sv
// raster_sequencer_pkg
//   Shared definitions for the raster sequencer: controller state encoding
//   and the default axis widths / coordinate offsets.
//   No ports (package).
package raster_sequencer_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_XW     = 10;
  localparam int DEF_YW     = 11;
  localparam int DEF_BASE_X = 100;
  localparam int DEF_BASE_Y = 200;

endpackage : raster_sequencer_pkg

// File: rtl/raster_sequencer_offset_unit.sv
// offset_unit
//   Purely combinational offset adder: x = BASE_X + dx, y = BASE_Y + dy,
//   both wrapping modulo 2^XW / 2^YW (offsets truncated to the axis width).
//   Ports:
//     dx_i [XW-1:0] x offset within the grid
//     dy_i [YW-1:0] y offset within the grid
//     x_o  [XW-1:0] absolute x coordinate
//     y_o  [YW-1:0] absolute y coordinate
module offset_unit
  import raster_sequencer_pkg::*;
#(
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW,
  parameter int BASE_X = DEF_BASE_X,
  parameter int BASE_Y = DEF_BASE_Y
) (
  input  logic [XW-1:0] dx_i,
  input  logic [YW-1:0] dy_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  localparam logic [XW-1:0] BASE_X_T = XW'(BASE_X);
  localparam logic [YW-1:0] BASE_Y_T = YW'(BASE_Y);

  // Same-width adds: the carry out is dropped, giving the modulo wrap.
  assign x_o = dx_i + BASE_X_T;
  assign y_o = dy_i + BASE_Y_T;

endmodule : offset_unit

// File: rtl/raster_sequencer.sv
// raster_sequencer
//   Walks a cols x rows grid and emits one (x,y) coordinate per valid/ready
//   handshake. x/y come from the offset_unit fed with the next-state dx/dy,
//   so every output is registered.
//   Optional build macro: RASTER_SEQUENCER_SERPENTINE_EN -- odd rows scan
//   right to left (boustrophedon); undefined means every row left to right.
//   Ports:
//     clock, rst_n      clock (rising edge), async active-low reset
//     start, cols, rows command strobe and grid size (sampled in IDLE)
//     abort             terminate the scan in progress
//     out_valid/ready   beat handshake; out_x/out_y coordinate, out_last
//                       final beat of the grid
//     busy              high in RUN and DONE
//     done              one-cycle pulse on normal completion
module raster_sequencer
  import raster_sequencer_pkg::*;
#(
  parameter int XW     = DEF_XW,
  parameter int YW     = DEF_YW,
  parameter int BASE_X = DEF_BASE_X,
  parameter int BASE_Y = DEF_BASE_Y
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] cols,
  input  logic [YW-1:0] rows,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [XW-1:0] dx_q, dx_d, cols_q, cols_d;
  logic [YW-1:0] dy_q, dy_d, rows_q, rows_d;
  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;
  logic          out_valid_d, out_last_d, busy_d, done_d;
  logic          beat_last_s;

  // True when (dx,dy) is the final beat of the grid in scan order.
  function automatic logic is_last_f(input logic [XW-1:0] dx, input logic [YW-1:0] dy,
                                     input logic [XW-1:0] c,  input logic [YW-1:0] r);
    logic row_end;
`ifdef RASTER_SEQUENCER_SERPENTINE_EN
    if (dy[0]) begin
      row_end = (dx == '0);
    end else begin
      row_end = (dx == c - XW'(1));
    end
`else
    row_end = (dx == c - XW'(1));
`endif
    return row_end && (dy == r - YW'(1));
  endfunction

  assign beat_last_s = is_last_f(dx_q, dy_q, cols_q, rows_q);

  offset_unit #(
    .XW(XW), .YW(YW), .BASE_X(BASE_X), .BASE_Y(BASE_Y)
  ) u_offset (
    .dx_i(dx_d),
    .dy_i(dy_d),
    .x_o (x_s),
    .y_o (y_s)
  );

  // State, counter and latched-dimension registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      cols_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
    end
  end

  // Next-state and counter advance.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cols_d  = cols_q;
    rows_d  = rows_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cols_d = cols;
          rows_d = rows;
          dx_d   = '0;
          dy_d   = '0;
          // An empty grid completes immediately without emitting beats.
          if ((cols != '0) && (rows != '0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A consumed last beat beats a simultaneous abort.
        if (out_ready && beat_last_s) begin
          state_d = ST_DONE;
          dx_d    = '0;
          dy_d    = '0;
        end else if (abort) begin
          state_d = ST_IDLE;
          dx_d    = '0;
          dy_d    = '0;
        end else if (out_ready) begin
`ifdef RASTER_SEQUENCER_SERPENTINE_EN
          // At a row end dx stays put: the next row starts at the same column.
          if (dy_q[0]) begin
            if (dx_q == '0) begin
              dy_d = dy_q + YW'(1);
            end else begin
              dx_d = dx_q - XW'(1);
            end
          end else begin
            if (dx_q == cols_q - XW'(1)) begin
              dy_d = dy_q + YW'(1);
            end else begin
              dx_d = dx_q + XW'(1);
            end
          end
`else
          if (dx_q == cols_q - XW'(1)) begin
            dx_d = '0;
            dy_d = dy_q + YW'(1);
          end else begin
            dx_d = dx_q + XW'(1);
          end
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values, derived from the next state so outputs can be registered.
  always_comb begin
    out_valid_d = (state_d == ST_RUN);
    out_last_d  = (state_d == ST_RUN) && is_last_f(dx_d, dy_d, cols_d, rows_d);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // Output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_x     <= XW'(BASE_X);
      out_y     <= YW'(BASE_Y);
    end else begin
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
      out_x     <= x_s;
      out_y     <= y_s;
    end
  end

endmodule : raster_sequencer

// File: tb/tb_raster_sequencer.sv
// Scoreboard bench for raster_sequencer: stimulus pushes expected beats,
// a negedge monitor compares every presented beat and the done pulse.
module tb_raster_sequencer;

  localparam int XW = 10;
  localparam int YW = 11;
  localparam int BX = 100;
  localparam int BY = 200;

  logic          clock = 1'b0;
  logic          rst_n, start, abort, out_ready;
  logic [XW-1:0] cols;
  logic [YW-1:0] rows;
  logic          out_valid, out_last, busy, done;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  // Narrow instance for the wrap-around case.
  logic          w_start, w_ready, w_valid, w_last, w_busy, w_done;
  logic [3:0]    w_cols, w_x;
  logic [YW-1:0] w_rows, w_y;

  always #5 clock = ~clock;

  raster_sequencer #(.XW(XW), .YW(YW), .BASE_X(BX), .BASE_Y(BY)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .cols(cols), .rows(rows),
    .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_last(out_last), .busy(busy), .done(done)
  );

  raster_sequencer #(.XW(4), .YW(YW), .BASE_X(14), .BASE_Y(BY)) u_wrap (
    .clock(clock), .rst_n(rst_n), .start(w_start), .cols(w_cols), .rows(w_rows),
    .abort(1'b0), .out_valid(w_valid), .out_ready(w_ready), .out_x(w_x),
    .out_y(w_y), .out_last(w_last), .busy(w_busy), .done(w_done)
  );

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    pending = 1'b0;
  int    done_due = 0;
  bit    idle_next = 1'b0;
  int    last_done_cyc = -1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference grid: row-major walk, odd rows reversed in serpentine builds.
  task automatic push_grid(input int c, input int r);
    beat_t b;
    int dx;
    for (int yy = 0; yy < r; yy++) begin
      for (int k = 0; k < c; k++) begin
        dx = k;
`ifdef RASTER_SEQUENCER_SERPENTINE_EN
        if (yy % 2 == 1) dx = c - 1 - k;
`endif
        b.x    = XW'(BX + dx);
        b.y    = YW'(BY + yy);
        b.last = (yy == r - 1) && (k == c - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  function automatic logic ready_for(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 3 == 0);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Monitor: compare each presented beat, pop on handshake, track done.
  initial begin
    forever begin
      @(negedge clock);
      if (rst_n) begin
        if (idle_next) begin
          chk("busy_after_done", busy, 0);
          idle_next = 1'b0;
        end
        if (done) begin
          chk("done_expected", pending, 1);
          if (pending) chk("done_cycle", cyc, done_due);
          chk("busy_in_done", busy, 1);
          chk("valid_in_done", out_valid, 0);
          pending = 1'b0;
          idle_next = 1'b1;
          last_done_cyc = cyc;
        end else if (pending && cyc > done_due) begin
          chk("done_missing", done, 1);
          pending = 1'b0;
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", out_valid, 0);
          end else begin
            chk("beat_x", out_x, exp_q[0].x);
            chk("beat_y", out_y, exp_q[0].y);
            chk("beat_last", out_last, exp_q[0].last);
            if (out_ready) begin
              if (exp_q[0].last) begin
                pending = 1'b1;
                done_due = cyc + 1;
              end
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic run_scan(input int c, input int r, input int mode, input int abort_at_i,
                          input bit inject);
    int total = c * r;
    int guard = 0;
    int i = 0;
    int abort_at = abort_at_i;
    int start_cyc;
    bit ab_nonlast = 1'b0;
    @(posedge clock); #1;
    while (busy && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
    end
    push_grid(c, r);
    cols = XW'(c);
    rows = YW'(r);
    start = 1'b1;
    start_cyc = cyc;
    if (total == 0) begin
      pending = 1'b1;
      done_due = cyc + 1;
    end
    out_ready = ready_for(mode, 0);
    guard = 0;
    do begin
      @(posedge clock); #1;
      guard++;
      i++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        if (ab_nonlast) begin
          exp_q.delete();
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          ab_nonlast = 1'b0;
        end
      end
      out_ready = ready_for(mode, i);
      // Start while busy must be ignored.
      if (inject && i == 2 && exp_q.size() > 2) begin
        start = 1'b1;
        cols = XW'(7);
        rows = YW'(7);
      end
      if (abort_at >= 0 && out_valid && exp_q.size() > 0 &&
          (total - exp_q.size()) == abort_at) begin
        abort = 1'b1;
        if (abort_at == total - 1) begin
          out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
          ab_nonlast = 1'b1;
        end
        abort_at = -1;
      end
    end while ((exp_q.size() != 0 || busy || pending || abort) && guard < 5000);
    if (guard >= 5000) chk("scan_timeout", 0, 1);
    if (mode == 0 && abort_at_i < 0 && total > 0)
      chk("scan_latency", last_done_cyc, start_cyc + total + 1);
    out_ready = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic reset_mid_scan();
    @(posedge clock); #1;
    push_grid(3, 2);
    cols = XW'(3);
    rows = YW'(2);
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_x", out_x, BX);
    exp_q.delete();
    pending = 1'b0;
    idle_next = 1'b0;
    #8 rst_n = 1'b1;
    out_ready = 1'b0;
    @(posedge clock); #1;
    chk("rst_after_valid", out_valid, 0);
  endtask

  task automatic wrap_test();
    logic [3:0] ex;
    w_cols = 4'd4;
    w_rows = YW'(1);
    w_ready = 1'b1;
    @(posedge clock); #1;
    w_start = 1'b1;
    @(posedge clock); #1;
    w_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      ex = 4'((14 + k) % 16);
      chk("wrap_valid", w_valid, 1);
      chk("wrap_x", w_x, ex);
      chk("wrap_y", w_y, BY);
      chk("wrap_last", w_last, (k == 3));
    end
    @(negedge clock);
    chk("wrap_valid_end", w_valid, 0);
    chk("wrap_done", w_done, 1);
  endtask

  initial begin
    int c, r, ab;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    cols = '0;
    rows = '0;
    w_start = 1'b0;
    w_ready = 1'b0;
    w_cols = '0;
    w_rows = '0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", out_x, BX);
    chk("rst_y", out_y, BY);
    #10 rst_n = 1'b1;

    run_scan(3, 2, 0, -1, 1'b0);   // basic
    run_scan(3, 2, 1, -1, 1'b0);   // backpressure 1,0,0,1,...
    run_scan(0, 5, 0, -1, 1'b0);   // zero dimension
    run_scan(4, 0, 0, -1, 1'b0);
    run_scan(3, 2, 0, 2, 1'b0);    // abort on 3rd beat
    run_scan(3, 2, 0, -1, 1'b1);   // fresh start accepted, ignored restart
    run_scan(3, 2, 0, 5, 1'b0);    // abort with last handshake: completion
    run_scan(1, 1, 0, -1, 1'b0);
    reset_mid_scan();
    run_scan(2, 3, 0, -1, 1'b0);
    wrap_test();

    for (int t = 0; t < 25; t++) begin
      c = $urandom_range(0, 5);
      r = $urandom_range(0, 4);
      ab = -1;
      if (c * r > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, c * r - 1);
      run_scan(c, r, 2, ab, 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_raster_sequencer
